// File: rtl/uart_frame_xfer.sv
// Frame mover between the UART FIFOs and a single-port frame RAM, with a processor hand-off in between.
// Optional inbound/outbound checksum byte: define UART_XFER_CKSUM_EN.
module uart_frame_xfer #(
  parameter int         ADDR_W = 12,
  parameter int         NPIX   = 4096,
  parameter logic [7:0] RX_HDR = 8'hA5,
  parameter logic [7:0] TX_HDR = 8'h5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              proc_done,
  output logic              frame_rx_done,
  output logic              frame_tx_done,
  output logic              cksum_err,
  output logic              busy
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NPIX - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_DATA,
    S_WAIT_PROC,
    S_TX_HDR,
    S_TX_RD,
    S_TX_LAT,
    S_TX_PUSH
`ifdef UART_XFER_CKSUM_EN
    , S_RX_CKSUM,
    S_TX_CKSUM
`endif
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic [7:0]        sum, sum_n;
  logic              tx_last, tx_last_n;
  logic              wr_uart_n, mem_we_n, frame_rx_done_n, frame_tx_done_n, cksum_err_n;
  logic [7:0]        w_data_n, mem_wdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              rx_state;

  // FIFO handshake: a byte moves on rd_uart & ~rx_empty (same-cycle consume) or on wr_uart, which is only raised after tx_full was seen low.
  always_comb begin
    rx_state = (state == S_IDLE) || (state == S_RX_DATA);
`ifdef UART_XFER_CKSUM_EN
    rx_state = rx_state || (state == S_RX_CKSUM);
`endif
    rd_uart = rx_state && !rx_empty;
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    sum_n           = sum;
    tx_last_n       = 1'b0;
    wr_uart_n       = 1'b0;
    w_data_n        = w_data;
    mem_addr_n      = mem_addr;
    mem_we_n        = 1'b0;
    mem_wdata_n     = mem_wdata;
    frame_rx_done_n = 1'b0;
    frame_tx_done_n = tx_last;
    cksum_err_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_empty && r_data == RX_HDR) begin
          cnt_n   = '0;
          sum_n   = '0;
          state_n = S_RX_DATA;
        end
      end
      S_RX_DATA: begin
        if (!rx_empty) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = cnt[ADDR_W-1:0];
          mem_wdata_n = r_data;
          sum_n       = sum + r_data;
          cnt_n       = cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef UART_XFER_CKSUM_EN
            state_n = S_RX_CKSUM;
`else
            frame_rx_done_n = 1'b1;
            state_n         = S_WAIT_PROC;
`endif
          end
        end
      end
`ifdef UART_XFER_CKSUM_EN
      S_RX_CKSUM: begin
        if (!rx_empty) begin
          if (r_data == sum) begin
            frame_rx_done_n = 1'b1;
            state_n         = S_WAIT_PROC;
          end else begin
            cksum_err_n = 1'b1;
            state_n     = S_IDLE;
          end
        end
      end
`endif
      S_WAIT_PROC: begin
        if (proc_done) begin
          cnt_n   = '0;
          sum_n   = '0;
          state_n = S_TX_HDR;
        end
      end
      S_TX_HDR: begin
        if (!tx_full) begin
          wr_uart_n  = 1'b1;
          w_data_n   = TX_HDR;
          mem_addr_n = cnt[ADDR_W-1:0];
          state_n    = S_TX_RD;
        end
      end
      // Address is already on the RAM during TX_RD, so read data is valid in TX_LAT.
      S_TX_RD: begin
        mem_addr_n = cnt[ADDR_W-1:0];
        state_n    = S_TX_LAT;
      end
      S_TX_LAT: begin
        w_data_n = mem_rdata;
        sum_n    = sum + mem_rdata;
        state_n  = S_TX_PUSH;
      end
      S_TX_PUSH: begin
        if (!tx_full) begin
          wr_uart_n = 1'b1;
          cnt_n     = cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef UART_XFER_CKSUM_EN
            state_n = S_TX_CKSUM;
`else
            tx_last_n = 1'b1;
            state_n   = S_IDLE;
`endif
          end else begin
            mem_addr_n = cnt_n[ADDR_W-1:0];
            state_n    = S_TX_RD;
          end
        end
      end
`ifdef UART_XFER_CKSUM_EN
      S_TX_CKSUM: begin
        if (!tx_full) begin
          wr_uart_n = 1'b1;
          w_data_n  = sum;
          tx_last_n = 1'b1;
          state_n   = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // frame_tx_done trails the final push by one cycle through tx_last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      sum           <= '0;
      tx_last       <= 1'b0;
      wr_uart       <= 1'b0;
      w_data        <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      frame_rx_done <= 1'b0;
      frame_tx_done <= 1'b0;
      cksum_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      sum           <= sum_n;
      tx_last       <= tx_last_n;
      wr_uart       <= wr_uart_n;
      w_data        <= w_data_n;
      mem_addr      <= mem_addr_n;
      mem_we        <= mem_we_n;
      mem_wdata     <= mem_wdata_n;
      frame_rx_done <= frame_rx_done_n;
      frame_tx_done <= frame_tx_done_n;
      cksum_err     <= cksum_err_n;
      busy          <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_frame_xfer.sv
// Bench for uart_frame_xfer with NPIX=4: RX/TX FIFO and frame RAM models, write and byte scoreboards.
module tb_uart_frame_xfer;
  localparam int         ADDR_W = 2;
  localparam int         NPIX   = 4;
  localparam logic [7:0] RX_HDR = 8'hA5;
  localparam logic [7:0] TX_HDR = 8'h5A;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_empty = 1'b1;
  logic [7:0]        r_data = 8'h00;
  logic              rd_uart;
  logic              tx_full = 1'b0;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              proc_done = 1'b0;
  logic              frame_rx_done, frame_tx_done, cksum_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_count = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int err_cnt = 0;
  int last_wr_cyc = 0;
  int exp_rx_done = 0;
  int exp_err = 0;
  bit gap_chk = 1'b0;

  logic [7:0]        rx_q[$];
  logic [7:0]        exp_q[$];
  logic [ADDR_W+7:0] exp_wr_q[$];
  logic [7:0]        ram[NPIX];
  logic              preload = 1'b0;
  logic              popped = 1'b0;

  uart_frame_xfer #(.ADDR_W(ADDR_W), .NPIX(NPIX), .RX_HDR(RX_HDR), .TX_HDR(TX_HDR)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .proc_done(proc_done),
    .frame_rx_done(frame_rx_done), .frame_tx_done(frame_tx_done), .cksum_err(cksum_err),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RX FIFO model: a byte shown with rd_uart high at a posedge is consumed there.
  always @(posedge clk) popped <= rd_uart;
  always @(negedge clk) begin
    if (popped && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_empty = (rx_q.size() == 0);
    r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // frame RAM model with 1-cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= 8'(i + 1);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // scoreboard / monitor
  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_uart) begin
      tx_count++;
      check("wr_while_full", 32'(tx_full), 32'(0));
      if (exp_q.size() == 0) check("tx_extra", 32'(w_data), 32'hFFFF_FFFF);
      else check("tx_byte", 32'(w_data), 32'(exp_q.pop_front()));
      if (gap_chk && tx_count >= 2 && tx_count <= NPIX + 1)
        check("tx_gap", 32'(cyc - last_wr_cyc), 32'(3));
      last_wr_cyc = cyc;
    end
    if (frame_tx_done) begin
      tx_done_cnt++;
      check("tx_done_lat", 32'(cyc - last_wr_cyc), 32'(1));
    end
    if (mem_we) begin
      if (exp_wr_q.size() == 0) check("ram_wr_extra", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
      else check("ram_wr", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
    end
    if (frame_rx_done) rx_done_cnt++;
    if (cksum_err) err_cnt++;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit pixel, input logic [ADDR_W-1:0] a);
    rx_q.push_back(b);
    if (pixel) exp_wr_q.push_back({a, b});
  endtask

  task automatic send_frame(input logic [31:0] px);
    send_byte(RX_HDR, 1'b0, '0);
    for (int i = 0; i < NPIX; i++) send_byte(px[31-8*i -: 8], 1'b1, ADDR_W'(i));
  endtask

  task automatic expect_tx(input logic [31:0] px, input logic [7:0] ck);
    exp_q.push_back(TX_HDR);
    for (int i = 0; i < NPIX; i++) exp_q.push_back(px[31-8*i -: 8]);
`ifdef UART_XFER_CKSUM_EN
    exp_q.push_back(ck);
`else
    if (ck == 8'h00) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic wait_rx_drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0) break;
    end
    check({tag, "_drain"}, 32'(rx_q.size()), 32'(0));
  endtask

  task automatic wait_tx_count(input int n, input string tag);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (tx_count >= n) break;
    end
    check({tag, "_tx_wait"}, 32'(tx_count >= n), 32'(1));
  endtask

  task automatic wait_tx_done(input int n, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (tx_done_cnt >= n) break;
    end
    check({tag, "_tx_done"}, 32'(tx_done_cnt), 32'(n));
  endtask

  task automatic pulse_proc_done();
    @(negedge clk); proc_done = 1'b1;
    @(negedge clk); proc_done = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_uart"}, 32'(rd_uart), 32'(0));
    check({tag, "_wr_uart"}, 32'(wr_uart), 32'(0));
    check({tag, "_w_data"}, 32'(w_data), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check({tag, "_rx_done"}, 32'(frame_rx_done), 32'(0));
    check({tag, "_tx_done"}, 32'(frame_tx_done), 32'(0));
    check({tag, "_cksum_err"}, 32'(cksum_err), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); check_reset_values(tag);
    reset = 1'b0;
  endtask

  task automatic check_ram(input string tag, input logic [31:0] px);
    for (int i = 0; i < NPIX; i++) check(tag, 32'(ram[i]), 32'(px[31-8*i -: 8]));
  endtask

  initial begin
    logic [7:0] no_ck;
    no_ck = 8'h01;
    repeat (3) @(negedge clk);
    check_reset_values("rst0");
    reset = 1'b0;

    // inbound frame with a leading junk byte; proc_done pulsed mid-frame
    @(negedge clk);
    send_byte(8'h00, 1'b0, '0);
    send_frame(32'h10203040);
    exp_rx_done++;
    repeat (3) @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk); proc_done = 1'b0;
    wait_rx_drain("t1");
    repeat (20) @(negedge clk);
    check("t1_rx_done", 32'(rx_done_cnt), 32'(exp_rx_done));
    check("t1_busy_wait", 32'(busy), 32'(1));
    check("t1_no_tx", 32'(tx_count), 32'(0));
    check_ram("t1_ram", 32'h10203040);

    // outbound frame from preloaded RAM, pixel pushes 3 cycles apart
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    tx_count = 0;
    gap_chk  = 1'b1;
    expect_tx(32'h01020304, 8'h0A);
    pulse_proc_done();
    wait_tx_done(1, "t2");
    @(negedge clk);
    check("t2_exp_left", 32'(exp_q.size()), 32'(0));
    check("t2_busy", 32'(busy), 32'(0));
    gap_chk = 1'b0;

`ifdef UART_XFER_CKSUM_EN
    // checksum match, then mismatch
    send_frame(32'h10203040);
    send_byte(8'hA0, 1'b0, '0);
    exp_rx_done++;
    wait_rx_drain("t3a");
    repeat (3) @(negedge clk);
    check("t3a_rx_done", 32'(rx_done_cnt), 32'(exp_rx_done));
    check("t3a_busy", 32'(busy), 32'(1));
    apply_reset("t3rst");
    send_frame(32'h10203040);
    send_byte(8'hA1, 1'b0, '0);
    exp_err++;
    wait_rx_drain("t3b");
    repeat (3) @(negedge clk);
    check("t3b_cksum_err", 32'(err_cnt), 32'(exp_err));
    check("t3b_rx_done", 32'(rx_done_cnt), 32'(exp_rx_done));
    check("t3b_busy", 32'(busy), 32'(0));
`endif

    // reset in the middle of an inbound frame leaves partial writes, then a clean frame
    send_byte(RX_HDR, 1'b0, '0);
    send_byte(8'h10, 1'b1, 2'd0);
    send_byte(8'h20, 1'b1, 2'd1);
    wait_rx_drain("t4a");
    apply_reset("midrst");
    send_frame(32'h55667788);
    exp_rx_done++;
    wait_rx_drain("t4b");
    repeat (3) @(negedge clk);
    check("t4_rx_done", 32'(rx_done_cnt), 32'(exp_rx_done));
    check_ram("t4_ram", 32'h55667788);

    // tx_full held for 10 cycles while pixel 2 waits in TX_PUSH
    tx_count = 0;
    expect_tx(32'h55667788, 8'hBA);
    pulse_proc_done();
    wait_tx_count(3, "t5");
    @(negedge clk); tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("stall_wr", 32'(wr_uart), 32'(0));
    end
    @(negedge clk); tx_full = 1'b0;
    wait_tx_done(2, "t5");
    @(negedge clk);
    check("t5_exp_left", 32'(exp_q.size()), 32'(0));
`ifdef UART_XFER_CKSUM_EN
    check("t5_tx_count", 32'(tx_count), 32'(NPIX + 2));
`else
    check("t5_tx_count", 32'(tx_count), 32'(NPIX + 1));
`endif

    repeat (5) @(negedge clk);
    check("end_wr_left", 32'(exp_wr_q.size()), 32'(0));
    check("end_rx_done", 32'(rx_done_cnt), 32'(exp_rx_done));
    check("end_cksum_err", 32'(err_cnt), 32'(exp_err));
    check("end_tx_done", 32'(tx_done_cnt), 32'(2));
    check("end_busy", 32'(busy), 32'(0));
    if (no_ck == 8'h00) check("unused", 32'(0), 32'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_xfer.md
# uart_frame_xfer

Host-side client of the UART FIFO interface that moves one image frame per transaction between a PC and the on-chip frame memory. It pops bytes from the UART receive FIFO, recognises a header, and writes the pixel bytes into a single-port frame RAM. It hands the frame to the image processor, then reads the processed frame back and pushes it, with its own header, into the UART transmit FIFO. It sits between the `uart` top and the frame memory / processing core.

## Interface
- `ADDR_W`, 12: frame RAM address width.
- `NPIX`, 4096: pixels (bytes) per frame; 1 ≤ NPIX ≤ 2^ADDR_W.
- `RX_HDR`, 8'hA5: header byte that starts an inbound frame.
- `TX_HDR`, 8'h5A: header byte that precedes an outbound frame.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `rx_empty` in 1: UART RX FIFO empty.
- `r_data` in 8: RX FIFO head byte, valid while `rx_empty`=0.
- `rd_uart` out 1: pop the RX FIFO.
- `tx_full` in 1: UART TX FIFO full.
- `wr_uart` out 1: push `w_data` into the TX FIFO.
- `w_data` out 8: byte to transmit.
- `mem_addr` out ADDR_W: frame RAM address.
- `mem_we` out 1: frame RAM write enable.
- `mem_wdata` out 8: frame RAM write data.
- `mem_rdata` in 8: frame RAM read data; valid 1 cycle after `mem_addr`.
- `proc_done` in 1: processor finished; level.
- `frame_rx_done` out 1: 1-cycle pulse when a full frame is stored.
- `frame_tx_done` out 1: 1-cycle pulse when the last outbound byte is pushed.
- `cksum_err` out 1: 1-cycle pulse on inbound checksum mismatch.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rd_uart` is combinational: `rd_uart` = (state ∈ {IDLE, RX_DATA, RX_CKSUM}) & ~`rx_empty`. The byte on `r_data` is consumed in the same cycle.
- Other outputs are registered.
- **IDLE**: pop every available byte. If the byte = `RX_HDR`, clear `cnt` and the sum, then go to RX_DATA. Any other byte is discarded.
- **RX_DATA**: on each pop:
  - drive `mem_we`=1, `mem_addr`=`cnt`, `mem_wdata`=byte (registered, so the write lands 1 cycle later);
  - add the byte to an 8-bit mod-256 sum;
  - `cnt`++.
  - On the pop where `cnt`=NPIX-1, go to RX_CKSUM if the macro is defined, otherwise pulse `frame_rx_done` and go to WAIT_PROC.
- **WAIT_PROC**: `proc_done` is sampled only in this state. When it is 1, clear `cnt` and go to TX_HDR. A `proc_done` asserted earlier has no effect.
- **TX_HDR**: when `tx_full`=0, drive `wr_uart`=1, `w_data`=`TX_HDR`, then go to TX_RD.
- **TX_RD**: drive `mem_addr`=`cnt`, then go to TX_LAT.
- **TX_LAT**: latch `mem_rdata` into `w_data` and add it to the sum, then go to TX_PUSH.
- **TX_PUSH**: hold until `tx_full`=0, then pulse `wr_uart` and `cnt`++.
  - If the pushed byte was pixel NPIX-1, go to TX_CKSUM if the macro is defined.
  - Otherwise in that case, pulse `frame_tx_done` and go to IDLE.
  - For any other pixel, go to TX_RD.
- `cnt` is ADDR_W+1 bits wide and never wraps within a frame; NPIX=2^ADDR_W is legal.
- `wr_uart` is never asserted while `tx_full`=1, and `rd_uart` is never asserted while `rx_empty`=1.
- Bytes arriving during WAIT_PROC and the TX states stay in the UART RX FIFO; they are not popped.
- A `reset` in any state returns the block to IDLE with all counters cleared. UART FIFO contents are untouched, and an aborted write leaves partial RAM contents.

## Timing
- Reset values: `rd_uart`=0 (because the state is IDLE and then depends on `rx_empty`), `wr_uart`=0, `w_data`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `frame_rx_done`=0, `frame_tx_done`=0, `cksum_err`=0, `busy`=0.
- Inbound: at most 1 byte per cycle. `mem_we` is asserted exactly 1 cycle after the pop.
- `frame_rx_done` is asserted the cycle after the last pixel pop (or after the checksum pop when the macro is defined).
- Outbound: a minimum of 3 cycles per pixel (TX_RD → TX_LAT → TX_PUSH) when `tx_full`=0. Each cycle with `tx_full`=1 adds 1 stall cycle.
- `frame_tx_done` is asserted the cycle after the final `wr_uart`.

## Configuration
- `UART_XFER_CKSUM_EN` defined:
  - Inbound: after the pixels, pop one more byte in RX_CKSUM and compare it with the sum. If they are equal, pulse `frame_rx_done` and go to WAIT_PROC. On a mismatch, pulse `cksum_err` and go to IDLE; no `frame_rx_done` is issued.
  - Outbound: TX_CKSUM pushes the sum of the outbound pixels once `tx_full`=0, then pulses `frame_tx_done`.
- `UART_XFER_CKSUM_EN` undefined: the RX_CKSUM and TX_CKSUM states and `cksum_err` logic are absent; `cksum_err` is tied to 0.

## Test plan
- NPIX=4. Feed 00,A5,10,20,30,40 → 00 is discarded. RAM[0..3] = 10,20,30,40. One `frame_rx_done` pulse, then `busy`=1 in WAIT_PROC.
- Preload RAM 01,02,03,04 and assert `proc_done` → TX FIFO receives 5A,01,02,03,04, then a `frame_tx_done` pulse; pixel pushes are spaced 3 cycles apart.
- Hold `tx_full`=1 for 10 cycles during TX_PUSH of pixel 2 → `wr_uart` stays 0 throughout, and byte 03 is pushed exactly once after release.
- `UART_XFER_CKSUM_EN` defined: A5,10,20,30,40,A0 → `frame_rx_done`. A5,10,20,30,40,A1 → `cksum_err` pulse, `busy`=0, no `frame_rx_done`. The outbound stream for 01..04 ends with 0A.
- Assert `reset` after A5,10,20 → next cycle `busy`=0, `mem_we`=0, all outputs at reset values. A following A5,55,66,77,88 loads RAM 55,66,77,88.
- Pulse `proc_done` during RX_DATA → ignored. `proc_done` is 0 in WAIT_PROC, so the block stays there with no TX activity.
